// File: rtl/button_input.sv
// Push-button input peripheral: synchronises and debounces each button,
// latches sticky press/release events and raises a level interrupt on enabled presses.
module button_input #(
   parameter int                  NUM_BTNS        = 7,
   parameter logic [NUM_BTNS-1:0] ACTIVE_LOW_MASK = 7'b0000001,
   parameter int                  TICK_DIV        = 25000,
   parameter int                  DEBOUNCE_TICKS  = 8
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic [NUM_BTNS-1:0] btn,
   input  logic                rd,
   input  logic                wr,
   input  logic [1:0]          addr,
   input  logic [15:0]         din,
   output logic [15:0]         dout,
   output logic                irq
);

   localparam int PW = $clog2(TICK_DIV);

   localparam logic [1:0] ADDR_STATE    = 2'd0;
   localparam logic [1:0] ADDR_PRESSED  = 2'd1;
   localparam logic [1:0] ADDR_IRQ_EN   = 2'd2;
   localparam logic [1:0] ADDR_RELEASED = 2'd3;

   logic [PW-1:0]              prescale_reg;
   logic                       tick;
   logic [NUM_BTNS-1:0]        sync1_reg;
   logic [NUM_BTNS-1:0]        sync_reg;
   logic [NUM_BTNS-1:0]        st_reg;
   logic [NUM_BTNS-1:0][3:0]   cnt_reg;
   logic [NUM_BTNS-1:0][3:0]   cnt_next;
   logic [NUM_BTNS-1:0]        commit;
   logic [NUM_BTNS-1:0]        pressed_reg;
   logic [NUM_BTNS-1:0]        pressed_next;
   logic [NUM_BTNS-1:0]        released_reg;
   logic [NUM_BTNS-1:0]        released_next;
   logic [NUM_BTNS-1:0]        irq_en_reg;
   logic [NUM_BTNS-1:0]        irq_en_next;
   logic [NUM_BTNS-1:0]        din_b;
   logic [NUM_BTNS-1:0]        rdata;
   logic [15:0]                dout_reg;
   logic                       irq_reg;

   assign tick  = (prescale_reg == PW'(TICK_DIV - 1));
   assign din_b = din[NUM_BTNS-1:0];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         prescale_reg <= '0;
      end else if (tick) begin
         prescale_reg <= '0;
      end else begin
         prescale_reg <= prescale_reg + PW'(1);
      end
   end

   // Polarity is normalised before the synchroniser so that 1 always means pressed.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync1_reg <= '0;
         sync_reg  <= '0;
      end else begin
         sync1_reg <= btn ^ ACTIVE_LOW_MASK;
         sync_reg  <= sync1_reg;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_debounce
         logic mismatch;
         assign mismatch    = sync_reg[gi] ^ st_reg[gi];
         assign commit[gi]  = mismatch & tick & (cnt_reg[gi] == 4'(DEBOUNCE_TICKS - 1));
         assign cnt_next[gi] = (!mismatch || commit[gi]) ? 4'd0 :
                               (tick ? cnt_reg[gi] + 4'd1 : cnt_reg[gi]);
      end
   endgenerate

   // Hardware set is OR-ed in after the W1C mask so a simultaneous event wins.
   always_comb begin
      pressed_next  = pressed_reg;
      released_next = released_reg;
      irq_en_next   = irq_en_reg;
      if (wr) begin
         case (addr)
            ADDR_PRESSED:  pressed_next  = pressed_reg & ~din_b;
            ADDR_IRQ_EN:   irq_en_next   = din_b;
            ADDR_RELEASED: released_next = released_reg & ~din_b;
            default: ;
         endcase
      end
      pressed_next  = pressed_next  | (commit & sync_reg);
      released_next = released_next | (commit & ~sync_reg);
   end

   always_comb begin
      rdata = '0;
      case (addr)
         ADDR_STATE:    rdata = st_reg;
         ADDR_PRESSED:  rdata = pressed_reg;
         ADDR_IRQ_EN:   rdata = irq_en_reg;
         ADDR_RELEASED: rdata = released_reg;
         default:       rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         st_reg       <= '0;
         cnt_reg      <= '0;
         pressed_reg  <= '0;
         released_reg <= '0;
         irq_en_reg   <= '0;
         dout_reg     <= '0;
         irq_reg      <= 1'b0;
      end else begin
         st_reg       <= st_reg ^ commit;
         cnt_reg      <= cnt_next;
         pressed_reg  <= pressed_next;
         released_reg <= released_next;
         irq_en_reg   <= irq_en_next;
         if (rd) begin
            dout_reg <= 16'(rdata);
         end
         irq_reg      <= |(pressed_reg & irq_en_reg);
      end
   end

   assign dout = dout_reg;
   assign irq  = irq_reg;

endmodule
